pulse_stretcher: RTL and testbench

Converts single-cycle event pulses, such as debounced push-button strobes, into a clean level of fixed length. The output level drives LEDs and seven-segment blanking, and acts as a hold-off for downstream counters. After each hold a lockout (guard) interval follows, during which new pulses are rejected. Rejected pulses are counted for diagnostics.

---
 rtl/pulse_stretcher.sv | 133 +++++++++++++
 tb/tb_pulse_stretcher.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle event strobes into a fixed-length
// level, followed by an optional guard interval that rejects new pulses.
// Rejected pulses are tallied in a saturating diagnostic counter.
module pulse_stretcher #(
    parameter int HOLD_CYCLES  = 10,   // level_out high time per accepted pulse, >= 1
    parameter int GUARD_CYCLES = 2,    // lockout after the hold, 0 = none
    parameter bit RETRIGGER    = 1'b0, // 1 = pulse during HOLD restarts the hold
    parameter int CNT_W        = 8     // width of drop_cnt
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic             level_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] drop_cnt
);

    // The shared down-counter only has to reach the larger of the two
    // interval lengths minus one; a floor of 2 keeps it at least 1 bit wide.
    localparam int MAX_HG = (HOLD_CYCLES > GUARD_CYCLES) ? HOLD_CYCLES : GUARD_CYCLES;
    localparam int CW     = $clog2((MAX_HG > 2) ? MAX_HG : 2);

    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? CW'(GUARD_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             level_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [CNT_W-1:0] drop_cnt_nxt;
    logic             seen;
    logic             drop;

    assign seen = pulse_in & enable;

    // Next-state, counter and output decode for the IDLE/HOLD/GUARD sequence.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        drop      = 1'b0;

        case (state)
            IDLE: begin
                if (seen) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end
            end

            HOLD: begin
                // A retrigger wins even on the final hold edge, so no done
                // strobe is issued when the hold is extended there.
                if (seen && RETRIGGER) begin
                    cnt_nxt = HOLD_LOAD;
                end else begin
                    drop = seen;
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                        if (GUARD_CYCLES > 0) begin
                            state_nxt = GUARD;
                            cnt_nxt   = GUARD_LOAD;
                        end else begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end
                end
            end

            GUARD: begin
                // Pulses are rejected right up to and including the last
                // guard edge; acceptance resumes once busy has fallen.
                drop = seen;
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        level_nxt = (state_nxt == HOLD);
        busy_nxt  = (state_nxt != IDLE);

        // Saturate rather than wrap so a flood of rejects stays visible.
        if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt_nxt = drop_cnt + 1'b1;
        end else begin
            drop_cnt_nxt = drop_cnt;
        end
    end

    // State register and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            level_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the values present before the edge, independent of statement order.
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_out <= level_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            drop_cnt  <= drop_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: four configurations share one stimulus stream
// and are compared every cycle against a time-based reference model that
// tracks, per configuration, the last cycle of the level and of busy.
module tb_pulse_stretcher;

    localparam int N = 4;
    // Configurations: 0 defaults, 1 retrigger, 2 narrow counter, 3 hold=1/no guard.
    localparam int HOLD_P  [N] = '{10, 10, 10, 1};
    localparam int GUARD_P [N] = '{2, 2, 2, 0};
    localparam int RETRIG_P[N] = '{0, 1, 0, 0};
    localparam int DMAX_P  [N] = '{255, 255, 3, 255};

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       pulse_in = 1'b0;
    logic       lvl [N];
    logic       bsy [N];
    logic       dn  [N];
    logic [7:0] dc0, dc1, dc3;
    logic [1:0] dc2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: last cycle the level is high, last cycle busy is high, drops.
    int lu [N];
    int bu [N];
    int drops [N];

    always #5 clk_in = ~clk_in;

    pulse_stretcher #(.HOLD_CYCLES(10), .GUARD_CYCLES(2), .RETRIGGER(1'b0), .CNT_W(8)) d0 (
        .clk_in(clk_in), .reset(reset), .enable(enable), .pulse_in(pulse_in),
        .level_out(lvl[0]), .busy(bsy[0]), .done(dn[0]), .drop_cnt(dc0));
    pulse_stretcher #(.HOLD_CYCLES(10), .GUARD_CYCLES(2), .RETRIGGER(1'b1), .CNT_W(8)) d1 (
        .clk_in(clk_in), .reset(reset), .enable(enable), .pulse_in(pulse_in),
        .level_out(lvl[1]), .busy(bsy[1]), .done(dn[1]), .drop_cnt(dc1));
    pulse_stretcher #(.HOLD_CYCLES(10), .GUARD_CYCLES(2), .RETRIGGER(1'b0), .CNT_W(2)) d2 (
        .clk_in(clk_in), .reset(reset), .enable(enable), .pulse_in(pulse_in),
        .level_out(lvl[2]), .busy(bsy[2]), .done(dn[2]), .drop_cnt(dc2));
    pulse_stretcher #(.HOLD_CYCLES(1), .GUARD_CYCLES(0), .RETRIGGER(1'b0), .CNT_W(8)) d3 (
        .clk_in(clk_in), .reset(reset), .enable(enable), .pulse_in(pulse_in),
        .level_out(lvl[3]), .busy(bsy[3]), .done(dn[3]), .drop_cnt(dc3));

    function automatic logic [7:0] drop_of(int k);
        case (k)
            0:       return dc0;
            1:       return dc1;
            2:       return {6'b0, dc2};
            default: return dc3;
        endcase
    endfunction

    function automatic logic [10:0] observe(int k);
        return {lvl[k], bsy[k], dn[k], drop_of(k)};
    endfunction

    // Expected outputs for the cycle currently visible (cycle number cyc).
    function automatic logic [10:0] expected(int k);
        logic l, b, d;
        l = (cyc <= lu[k]);
        b = (cyc <= bu[k]);
        d = (cyc == lu[k] + 1);
        return {l, b, d, 8'(drops[k])};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            lu[k]    = -10;
            bu[k]    = -10;
            drops[k] = 0;
        end
    endfunction

    // Apply the acceptance rules for a pulse seen on the edge ending cycle t.
    function automatic void model_edge(int t, bit seen);
        if (!seen) return;
        for (int k = 0; k < N; k++) begin
            if (t <= lu[k]) begin
                if (RETRIG_P[k] != 0) begin
                    lu[k] = t + HOLD_P[k];
                    bu[k] = lu[k] + GUARD_P[k];
                end else if (drops[k] < DMAX_P[k]) begin
                    drops[k]++;
                end
            end else if (t <= bu[k]) begin
                if (drops[k] < DMAX_P[k]) drops[k]++;
            end else begin
                lu[k] = t + HOLD_P[k];
                bu[k] = lu[k] + GUARD_P[k];
            end
        end
    endfunction

    // Drive inputs for the current cycle, take the edge, then settle 1 time unit.
    task automatic tick(input bit p, input bit en);
        pulse_in = p;
        enable   = en;
        @(posedge clk_in);
        if (!reset) model_edge(cyc, p && en);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        pulse_in = 1'b0;
        enable   = 1'b0;
        reset    = 1'b1;
        model_reset();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        #1;
        // Before any clock edge the asynchronous reset must already hold.
        for (int k = 0; k < N; k++) begin
            checks++;
            if (observe(k) !== 11'd0) begin
                errors++;
                $display("FAIL reset_async dut%0d: got %h expected %h", k, observe(k), 11'd0);
            end
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1);
            for (int k = 0; k < N; k++) begin
                checks++;
                if (observe(k) !== expected(k)) begin
                    errors++;
                    $display("FAIL reset_idle dut%0d cycle %0d: got %h expected %h",
                             k, cyc, observe(k), expected(k));
                end
            end
        end
    endtask

    task automatic test_single_pulse();
        int n_lvl = 0, n_done = 0, n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick(i == 5, 1'b1);
            for (int k = 0; k < N; k++) begin
                checks++;
                if (observe(k) !== expected(k)) begin
                    errors++;
                    $display("FAIL single_pulse dut%0d cycle %0d: got %h expected %h",
                             k, cyc, observe(k), expected(k));
                end
            end
            n_lvl  += int'(lvl[0]);
            n_done += int'(dn[0]);
            n_busy += int'(bsy[0]);
        end
        checks++;
        if (n_lvl !== 10) begin
            errors++;
            $display("FAIL single_pulse_level_len: got %0d expected %0d", n_lvl, 10);
        end
        checks++;
        if (n_done !== 1) begin
            errors++;
            $display("FAIL single_pulse_done_count: got %0d expected %0d", n_done, 1);
        end
        checks++;
        if (n_busy !== 12) begin
            errors++;
            $display("FAIL single_pulse_busy_len: got %0d expected %0d", n_busy, 12);
        end
        checks++;
        if (dc0 !== 8'd0) begin
            errors++;
            $display("FAIL single_pulse_drop: got %0d expected %0d", dc0, 0);
        end
    endtask

    // Pulses during HOLD and GUARD are rejected (the final guard edge too);
    // the first acceptance comes on the edge after busy falls.
    task automatic test_drop_guard();
        logic lvl_at_11, lvl_at_14;
        lvl_at_11 = 1'bx;
        lvl_at_14 = 1'bx;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tick(i == 0 || i == 4 || i == 11 || i == 12 || i == 13, 1'b1);
            for (int k = 0; k < N; k++) begin
                checks++;
                if (observe(k) !== expected(k)) begin
                    errors++;
                    $display("FAIL drop_guard dut%0d cycle %0d: got %h expected %h",
                             k, cyc, observe(k), expected(k));
                end
            end
            if (i == 10) lvl_at_11 = lvl[0];
            if (i == 13) lvl_at_14 = lvl[0];
        end
        checks++;
        if (dc0 !== 8'd3) begin
            errors++;
            $display("FAIL drop_guard_count: got %0d expected %0d", dc0, 3);
        end
        checks++;
        if (lvl_at_11 !== 1'b0 || lvl_at_14 !== 1'b1) begin
            errors++;
            $display("FAIL drop_guard_relevel: got %b%b expected 01", lvl_at_11, lvl_at_14);
        end
    endtask

    task automatic test_retrigger();
        int n_lvl = 0, n_done = 0;
        do_reset();
        // Retrigger mid-hold: 0 and 7 give 17 high cycles and one done.
        for (int i = 0; i < 30; i++) begin
            tick(i == 0 || i == 7, 1'b1);
            for (int k = 0; k < N; k++) begin
                checks++;
                if (observe(k) !== expected(k)) begin
                    errors++;
                    $display("FAIL retrigger dut%0d cycle %0d: got %h expected %h",
                             k, cyc, observe(k), expected(k));
                end
            end
            n_lvl  += int'(lvl[1]);
            n_done += int'(dn[1]);
        end
        checks++;
        if (n_lvl !== 17 || n_done !== 1) begin
            errors++;
            $display("FAIL retrigger_len: got level %0d done %0d expected level 17 done 1",
                     n_lvl, n_done);
        end
        // Retrigger on the exit edge: hold extends, no done in between.
        n_lvl  = 0;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick(i == 0 || i == 10, 1'b1);
            for (int k = 0; k < N; k++) begin
                checks++;
                if (observe(k) !== expected(k)) begin
                    errors++;
                    $display("FAIL retrigger_exit dut%0d cycle %0d: got %h expected %h",
                             k, cyc, observe(k), expected(k));
                end
            end
            n_lvl  += int'(lvl[1]);
            n_done += int'(dn[1]);
        end
        checks++;
        if (n_lvl !== 20 || n_done !== 1) begin
            errors++;
            $display("FAIL retrigger_exit_len: got level %0d done %0d expected level 20 done 1",
                     n_lvl, n_done);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        tick(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (dc2 !== want[i]) begin
                errors++;
                $display("FAIL saturate_step%0d: got %0d expected %0d", i, dc2, want[i]);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (observe(k) !== expected(k)) begin
                    errors++;
                    $display("FAIL saturate dut%0d cycle %0d: got %h expected %h",
                             k, cyc, observe(k), expected(k));
                end
            end
        end
        for (int i = 0; i < 15; i++) tick(1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        int n_lvl = 0;
        do_reset();
        tick(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        // Mid-cycle, well away from any edge.
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (observe(k) !== 11'd0) begin
                errors++;
                $display("FAIL async_reset dut%0d: got %h expected %h", k, observe(k), 11'd0);
            end
        end
        model_reset();
        tick(1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick(i == 0, 1'b1);
            for (int k = 0; k < N; k++) begin
                checks++;
                if (observe(k) !== expected(k)) begin
                    errors++;
                    $display("FAIL after_reset dut%0d cycle %0d: got %h expected %h",
                             k, cyc, observe(k), expected(k));
                end
            end
            n_lvl += int'(lvl[0]);
        end
        checks++;
        if (n_lvl !== 10) begin
            errors++;
            $display("FAIL after_reset_len: got %0d expected %0d", n_lvl, 10);
        end
    endtask

    // Level-held pulse: one pulse per edge, not edge-detected.
    task automatic test_held_pulse();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (lvl[3] !== ((i % 2) == 0) || dn[3] !== ((i % 2) == 1)) begin
                errors++;
                $display("FAIL held_alt step%0d: got level %b done %b expected level %b done %b",
                         i, lvl[3], dn[3], (i % 2) == 0, (i % 2) == 1);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (observe(k) !== expected(k)) begin
                    errors++;
                    $display("FAIL held dut%0d cycle %0d: got %h expected %h",
                             k, cyc, observe(k), expected(k));
                end
            end
        end
        checks++;
        if (dc3 !== 8'd4) begin
            errors++;
            $display("FAIL held_drop: got %0d expected %0d", dc3, 4);
        end
        tick(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (lvl[3] !== 1'b0 || dc3 !== 8'd4) begin
                errors++;
                $display("FAIL held_disabled step%0d: got level %b drop %0d expected level 0 drop 4",
                         i, lvl[3], dc3);
            end
        end
    endtask

    task automatic test_random();
        bit p, en;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            p  = ($urandom_range(0, 2) == 0);
            en = ($urandom_range(0, 9) != 0);
            tick(p, en);
            for (int k = 0; k < N; k++) begin
                checks++;
                if (observe(k) !== expected(k)) begin
                    errors++;
                    $display("FAIL random dut%0d cycle %0d: got %h expected %h",
                             k, cyc, observe(k), expected(k));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_pulse();
        test_drop_guard();
        test_retrigger();
        test_saturation();
        test_async_reset();
        test_held_pulse();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
